sd_reg_bank_arbiter: RTL and testbench
======================================

// Module: sd_reg_bank_arbiter
// PURPOSE
//   Bank of 2**ADDR_W byte-enable registers shared by two writers: the Wishbone host (wb_*) and the
//   SD core status/update port (core_*). Round-robin arbiter + 3-state FSM sequences one access per
//   grant; byte lanes written per select mask. Sits between the WB slave decode and the SD cmd/data cores.
// PARAMETERS
//   DATA_W  32                 register width in bits (any value >= 1)
//   EN_W    (DATA_W-1)/8+1     byte-enable width; last lane may be partial (bits DATA_W-1 : 8*(EN_W-1))
//   ADDR_W  3                  register index width; NREG = 2**ADDR_W registers
// PORTS
//   clk        in   1              clock, all state on rising edge
//   rst        in   1              asynchronous, active-low reset
//   wb_cyc_i   in   1              host cycle
//   wb_stb_i   in   1              host strobe; request = wb_cyc_i & wb_stb_i
//   wb_we_i    in   1              1 write, 0 read
//   wb_sel_i   in   EN_W           host byte enables
//   wb_adr_i   in   ADDR_W         host register index
//   wb_dat_i   in   DATA_W         host write data
//   wb_dat_o   out  DATA_W         host read data, valid while wb_ack_o=1
//   wb_ack_o   out  1              one-cycle access acknowledge
//   core_req_i in   1              core write request (held until core_gnt_o)
//   core_adr_i in   ADDR_W         core register index
//   core_sel_i in   EN_W           core byte enables
//   core_dat_i in   DATA_W         core write data
//   core_gnt_o out  1              one-cycle core write acknowledge
//   q_o        out  NREG*DATA_W    flattened bank; register i at q_o[i*DATA_W +: DATA_W]
// BEHAVIOUR
//   Reset: all registers 0, wb_dat_o=0, wb_ack_o=0, core_gnt_o=0, FSM=IDLE, last_grant=CORE.
//     Reset asserted mid-access clears everything immediately; in-flight ack/gnt lost (no retry).
//   FSM: IDLE -> GNT_HOST | GNT_CORE -> IDLE (unconditional). One access per 2 cycles max.
//   Arbitration in IDLE: only one requester -> grant it; both -> grant the one not in last_grant
//     (round-robin); none -> stay IDLE. last_grant updated on every grant.
//   Commit: write applied on the IDLE->GNT_x edge; for each lane k with sel[k]=1, reg[adr] lane k <=
//     data lane k; lanes with sel[k]=0 hold. sel=0 write: acked, no change. Read: wb_dat_o <= reg[adr]
//     on the same edge (value before any same-edge core write; only one writer per edge anyway).
//   Latency: request seen in IDLE at edge N -> q_o updated and ack/gnt high after edge N, low after N+1.
//   Host dropping wb_stb_i during GNT_HOST: access already committed; ack still pulses one cycle.
//   Requests sampled again only in IDLE; a held request after ack is treated as a new access.
//   wb_dat_o holds its last value when wb_ack_o=0.
// CONFIGURATION
//   SD_REG_BANK_LOCK_EN defined: register NREG-1 bit 0 is LOCK. While LOCK=1, host writes to
//     registers 0..NREG-2 are acked but discarded; host may still write register NREG-1 (to unlock);
//     core writes and host reads unaffected.
//   Not defined: register NREG-1 is an ordinary register, no write filtering.
// TESTING (DATA_W=32, ADDR_W=3)
//   1 Reset: hold rst=0 3 cycles -> q_o all 0, wb_ack_o=0, core_gnt_o=0; release, idle 5 cycles, no change.
//   2 Host write adr=2 sel=4'hf dat=32'h12345678 -> ack 1 cycle after request edge, reg2=32'h12345678;
//     then sel=4'h2 dat=32'hffffeeff -> reg2=32'h1234ee78; read adr=2 -> wb_dat_o=32'h1234ee78 with ack.
//   3 Simultaneous host(adr=1,dat=32'hAAAA_AAAA,sel=f) and core(adr=1,dat=32'h5555_5555,sel=3) held:
//     after reset, host granted first, core next -> reg1=32'hAAAA5555; alternation repeats each 4 cycles.
//   4 Core write sel=4'h0 adr=0 -> core_gnt_o pulses, reg0 unchanged; host read with stb dropped in
//     GNT_HOST -> ack still single 1-cycle pulse.
//   5 Reset asserted in GNT_CORE cycle -> core_gnt_o drops same cycle (async), all regs 0.
//   6 With SD_REG_BANK_LOCK_EN: host writes reg7=1, then reg3=32'hdeadbeef -> acked, reg3 stays 0; core
//     writes reg3=32'h1 -> reg3=1; host writes reg7=0, reg3=32'hdeadbeef -> reg3=32'hdeadbeef.

Source files
------------

// File: rtl/sd_reg_bank_arbiter.sv
// Register bank shared by a Wishbone host and the SD core update port, with round-robin arbitration.
// Optional macro SD_REG_BANK_LOCK_EN: bit 0 of the top register blocks host writes to the other registers.
module sd_reg_bank_arbiter #(
  parameter int DATA_W = 32,
  parameter int EN_W   = (DATA_W - 1) / 8 + 1,
  parameter int ADDR_W = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wb_cyc_i,
  input  logic                              wb_stb_i,
  input  logic                              wb_we_i,
  input  logic [EN_W-1:0]                   wb_sel_i,
  input  logic [ADDR_W-1:0]                 wb_adr_i,
  input  logic [DATA_W-1:0]                 wb_dat_i,
  output logic [DATA_W-1:0]                 wb_dat_o,
  output logic                              wb_ack_o,
  input  logic                              core_req_i,
  input  logic [ADDR_W-1:0]                 core_adr_i,
  input  logic [EN_W-1:0]                   core_sel_i,
  input  logic [DATA_W-1:0]                 core_dat_i,
  output logic                              core_gnt_o,
  output logic [(2**ADDR_W)*DATA_W-1:0]     q_o
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_HOST = 2'd1,
    GNT_CORE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_host_q, last_host_d;
  logic [DATA_W-1:0]   wb_dat_q, wb_dat_d;
  logic [DATA_W-1:0]   regs_q [NREG];

  logic                host_req;
  logic                host_wr_allowed;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_adr;
  logic [EN_W-1:0]     wr_sel;
  logic [DATA_W-1:0]   wr_dat;
  logic [DATA_W-1:0]   wr_mask;

  assign host_req = wb_cyc_i & wb_stb_i;

`ifdef SD_REG_BANK_LOCK_EN
  // The top register stays writable while locked so the host can clear LOCK.
  assign host_wr_allowed = ~regs_q[NREG-1][0] | (wb_adr_i == ADDR_W'(NREG - 1));
`else
  assign host_wr_allowed = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    last_host_d = last_host_q;
    wb_dat_d    = wb_dat_q;
    wr_en       = 1'b0;
    wr_adr      = core_adr_i;
    wr_sel      = core_sel_i;
    wr_dat      = core_dat_i;

    case (state_q)
      IDLE: begin
        // Host wins when alone, or when both request and the core was served last.
        if (host_req && (!core_req_i || !last_host_q)) begin
          state_d     = GNT_HOST;
          last_host_d = 1'b1;
          wr_adr      = wb_adr_i;
          wr_sel      = wb_sel_i;
          wr_dat      = wb_dat_i;
          if (wb_we_i) begin
            wr_en = host_wr_allowed;
          end else begin
            wb_dat_d = regs_q[wb_adr_i];
          end
        end else if (core_req_i) begin
          state_d     = GNT_CORE;
          last_host_d = 1'b0;
          wr_en       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Expand byte enables to a bit mask; the last lane may be narrower than 8 bits.
  for (genvar b = 0; b < DATA_W; b++) begin : g_mask
    assign wr_mask[b] = wr_sel[b / 8];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_host_q <= 1'b0;
      wb_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_host_q <= last_host_d;
      wb_dat_q    <= wb_dat_d;
    end
  end

  // NOTE: the bank is reset explicitly because software expects all registers to read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_adr] <= (regs_q[wr_adr] & ~wr_mask) | (wr_dat & wr_mask);
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign q_o[i*DATA_W +: DATA_W] = regs_q[i];
  end

  // Acknowledges come straight from state flops, so an async reset drops them at once.
  assign wb_ack_o   = (state_q == GNT_HOST);
  assign core_gnt_o = (state_q == GNT_CORE);
  assign wb_dat_o   = wb_dat_q;

endmodule

// File: tb/tb_sd_reg_bank_arbiter.sv
// Self-checking bench for sd_reg_bank_arbiter (DATA_W=32, ADDR_W=3) against a transaction-level model.
// Lock checks run only when SD_REG_BANK_LOCK_EN is defined for both bench and design.
module tb_sd_reg_bank_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]    wb_sel_i;
  logic [2:0]    wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          core_req_i;
  logic [2:0]    core_adr_i;
  logic [3:0]    core_sel_i;
  logic [31:0]   core_dat_i;
  logic          core_gnt_o;
  logic [255:0]  q_o;

  int n_pass  = 0;
  int n_total = 0;

  // Model: register contents, who was served last, last read data.
  logic [31:0] m_reg [8];
  bit          m_last_host;
  logic [31:0] m_rdat;

  always #5 clk = ~clk;

  sd_reg_bank_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_sel_i   (wb_sel_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .core_req_i (core_req_i),
    .core_adr_i (core_adr_i),
    .core_sel_i (core_sel_i),
    .core_dat_i (core_dat_i),
    .core_gnt_o (core_gnt_o),
    .q_o        (q_o)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = m_reg[i];
    return f;
  endfunction

  function automatic void m_write(input logic [2:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    for (int k = 0; k < 4; k++)
      if (sel[k]) m_reg[adr][8*k +: 8] = dat[8*k +: 8];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_last_host = 1'b0;
    m_rdat      = '0;
  endfunction

  function automatic bit m_host_blocked(input logic [2:0] adr);
`ifdef SD_REG_BANK_LOCK_EN
    return m_reg[7][0] && (adr != 3'd7);
`else
    return 1'b0;
`endif
  endfunction

  // Present an optional host access and an optional core write together at a negedge (FSM idle),
  // then follow each grant the model predicts. Ends on a negedge with the FSM idle again.
  task automatic do_pair(input bit h, input bit hwe, input logic [2:0] ha, input logic [3:0] hs,
                         input logic [31:0] hd, input bit c, input logic [2:0] ca,
                         input logic [3:0] cs, input logic [31:0] cd);
    bit pend_h = h;
    bit pend_c = c;
    bit exp_host;
    int waited;
    wb_cyc_i = h;  wb_stb_i = h;  wb_we_i = hwe;
    wb_adr_i = ha; wb_sel_i = hs; wb_dat_i = hd;
    core_req_i = c; core_adr_i = ca; core_sel_i = cs; core_dat_i = cd;
    if (!h && !c) begin
      @(negedge clk);
      check("idle_no_grant", {wb_ack_o, core_gnt_o}, 2'b00);
      check("idle_regs", q_o, m_flat());
    end
    while (pend_h || pend_c) begin
      exp_host = pend_h && (!pend_c || !m_last_host);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!wb_ack_o && !core_gnt_o && waited < 4);
      check("grant_who", {wb_ack_o, core_gnt_o}, exp_host ? 2'b10 : 2'b01);
      check("grant_latency", waited, 1);
      if (exp_host) begin
        if (hwe) begin
          if (!m_host_blocked(ha)) m_write(ha, hs, hd);
        end else begin
          m_rdat = m_reg[ha];
          check("read_data", wb_dat_o, m_rdat);
        end
        m_last_host = 1'b1;
        pend_h = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end else begin
        m_write(ca, cs, cd);
        m_last_host = 1'b0;
        pend_c = 1'b0;
        core_req_i = 1'b0;
      end
      check("bank", q_o, m_flat());
      @(negedge clk);
      check("pulse_end", {wb_ack_o, core_gnt_o}, 2'b00);
      check("rdat_hold", wb_dat_o, m_rdat);
    end
  endtask

  initial begin
    rst = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = '0; wb_adr_i = '0; wb_dat_i = '0;
    core_req_i = 0; core_adr_i = '0; core_sel_i = '0; core_dat_i = '0;
    m_reset();

    // Reset held for 3 cycles, then 5 quiet cycles.
    repeat (3) @(negedge clk);
    check("rst_bank", q_o, '0);
    check("rst_ack_gnt", {wb_ack_o, core_gnt_o}, 2'b00);
    check("rst_rdat", wb_dat_o, '0);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("quiet_bank", q_o, '0);
      check("quiet_ack_gnt", {wb_ack_o, core_gnt_o}, 2'b00);
    end

    // Host simultaneous with core on reg1: host first after reset.
    do_pair(1, 1, 3'd1, 4'hf, 32'hAAAA_AAAA, 1, 3'd1, 4'h3, 32'h5555_5555);
    check("dir_reg1", q_o[32 +: 32], 32'hAAAA5555);
    do_pair(1, 1, 3'd1, 4'hf, 32'hAAAA_AAAA, 1, 3'd1, 4'h3, 32'h5555_5555);
    check("dir_reg1_again", q_o[32 +: 32], 32'hAAAA5555);

    // Full and partial host writes, then readback.
    do_pair(1, 1, 3'd2, 4'hf, 32'h12345678, 0, '0, '0, '0);
    check("dir_reg2_full", q_o[64 +: 32], 32'h12345678);
    do_pair(1, 1, 3'd2, 4'h2, 32'hffffeeff, 0, '0, '0, '0);
    check("dir_reg2_lane1", q_o[64 +: 32], 32'h1234ee78);
    do_pair(1, 0, 3'd2, 4'h0, 32'h0, 0, '0, '0, '0);
    check("dir_reg2_read", wb_dat_o, 32'h1234ee78);

    // Core write with empty select, then a host read (stb is dropped during the grant).
    do_pair(0, 0, '0, '0, '0, 1, 3'd0, 4'h0, 32'hffff_ffff);
    check("dir_reg0_sel0", q_o[31:0], 32'h0);
    do_pair(1, 0, 3'd1, 4'h0, 32'h0, 0, '0, '0, '0);
    check("dir_reg1_read", wb_dat_o, 32'hAAAA5555);

`ifdef SD_REG_BANK_LOCK_EN
    do_pair(1, 1, 3'd7, 4'hf, 32'h1, 0, '0, '0, '0);
    do_pair(1, 1, 3'd3, 4'hf, 32'hdeadbeef, 0, '0, '0, '0);
    check("lock_blocks", q_o[96 +: 32], 32'h0);
    do_pair(0, 0, '0, '0, '0, 1, 3'd3, 4'hf, 32'h1);
    check("lock_core_ok", q_o[96 +: 32], 32'h1);
    do_pair(1, 1, 3'd7, 4'hf, 32'h0, 0, '0, '0, '0);
    do_pair(1, 1, 3'd3, 4'hf, 32'hdeadbeef, 0, '0, '0, '0);
    check("unlock_write", q_o[96 +: 32], 32'hdeadbeef);
`endif

    // Randomized mix of host reads/writes and core writes, including contention and sel=0.
    for (int it = 0; it < 60; it++) begin
      do_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom), $urandom,
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom), $urandom);
    end

    // Reset during a core grant: gnt and bank clear without waiting for a clock edge.
    do_pair(0, 0, '0, '0, '0, 1, 3'd4, 4'hf, 32'hcafe_f00d);
    core_req_i = 1'b1; core_adr_i = 3'd5; core_sel_i = 4'hf; core_dat_i = 32'h0bad_cafe;
    @(posedge clk);
    #1;
    check("pre_rst_gnt", core_gnt_o, 1'b1);
    rst = 1'b0;
    #1;
    m_reset();
    check("async_rst_gnt", {wb_ack_o, core_gnt_o}, 2'b00);
    check("async_rst_bank", q_o, m_flat());
    core_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_pair(1, 1, 3'd6, 4'h9, 32'h8765_4321, 1, 3'd6, 4'h6, 32'h1111_1111);
    check("post_rst_reg6", q_o[192 +: 32], 32'h87111121);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
